// File: rtl/sd_sector_arbiter.sv
// Arbitrates sector requests from the floppy (FDC) and ACSI clients onto one SD card controller.
// One transfer is in flight at a time; the two clients are served round-robin.
module sd_sector_arbiter #(
    parameter int TIMEOUT_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  fdc_rd_req,
    input  logic [1:0]  fdc_wr_req,
    input  logic [31:0] fdc_lba,
    input  logic [1:0]  acsi_rd_req,
    input  logic [1:0]  acsi_wr_req,
    input  logic [31:0] acsi_lba,
    input  logic [15:0] acsi_length,
    output logic        fdc_busy,
    output logic        acsi_busy,
    output logic        fdc_done,
    output logic        acsi_done,
    output logic [3:0]  sd_rd,
    output logic [3:0]  sd_wr,
    output logic [31:0] sd_lba,
    output logic [15:0] sd_length,
    input  logic        sd_busy,
    input  logic        sd_done,
    output logic        timeout_err
);

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RELEASE} state_t;

    state_t               state, state_next;
    logic                 owner_acsi;
    logic                 last_acsi;
    logic [TIMEOUT_W-1:0] wdog;
    logic [TIMEOUT_W-1:0] wdog_inc;

    logic       fdc_any, acsi_any, pick_acsi;
    logic [1:0] req_rd, req_wr;
    logic       sel_idx, sel_wr;
    logic [3:0] slot_onehot;
    logic       grant, issue_ack, done_ev, timeout_ev;

    assign wdog_inc = wdog + TIMEOUT_W'(1);

    // Client select: on a tie the client that was not granted last wins.
    assign fdc_any   = |{fdc_rd_req, fdc_wr_req};
    assign acsi_any  = |{acsi_rd_req, acsi_wr_req};
    assign pick_acsi = acsi_any & (~fdc_any | ~last_acsi);
    assign req_rd    = pick_acsi ? acsi_rd_req : fdc_rd_req;
    assign req_wr    = pick_acsi ? acsi_wr_req : fdc_wr_req;

    // Lowest index first; within one index, read before write.
    always_comb begin
        sel_idx = 1'b1;
        sel_wr  = 1'b1;
        if (req_rd[0]) begin
            sel_idx = 1'b0;
            sel_wr  = 1'b0;
        end else if (req_wr[0]) begin
            sel_idx = 1'b0;
            sel_wr  = 1'b1;
        end else if (req_rd[1]) begin
            sel_idx = 1'b1;
            sel_wr  = 1'b0;
        end
    end

    assign slot_onehot = 4'b0001 << {pick_acsi, sel_idx};

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        grant      = 1'b0;
        issue_ack  = 1'b0;
        done_ev    = 1'b0;
        timeout_ev = 1'b0;
        case (state)
            IDLE: begin
                if (fdc_any || acsi_any) begin
                    grant      = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (sd_busy) begin
                    issue_ack  = 1'b1;
                    state_next = BUSY;
                end else if (wdog_inc == '1) begin
                    timeout_ev = 1'b1;
                    state_next = IDLE;
                end
            end
            BUSY: begin
                if (sd_done) begin
                    done_ev    = 1'b1;
                    state_next = RELEASE;
                end
            end
            RELEASE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_acsi  <= 1'b0;
            last_acsi   <= 1'b1;
            wdog        <= '0;
            sd_rd       <= '0;
            sd_wr       <= '0;
            sd_lba      <= '0;
            sd_length   <= '0;
            fdc_busy    <= 1'b0;
            acsi_busy   <= 1'b0;
            fdc_done    <= 1'b0;
            acsi_done   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            fdc_done    <= 1'b0;
            acsi_done   <= 1'b0;
            timeout_err <= timeout_ev;

            if (grant) begin
                owner_acsi <= pick_acsi;
                wdog       <= '0;
                sd_lba     <= pick_acsi ? acsi_lba : fdc_lba;
                sd_length  <= pick_acsi ? acsi_length : 16'd1;
                sd_rd      <= sel_wr ? 4'b0000 : slot_onehot;
                sd_wr      <= sel_wr ? slot_onehot : 4'b0000;
            end

            if (state == ISSUE) wdog <= wdog_inc;

            if (issue_ack || timeout_ev) begin
                sd_rd <= '0;
                sd_wr <= '0;
            end

            if (issue_ack) begin
                fdc_busy  <= ~owner_acsi;
                acsi_busy <= owner_acsi;
            end

            if (done_ev) begin
                fdc_done  <= ~owner_acsi;
                acsi_done <= owner_acsi;
            end

            if (state == RELEASE) begin
                fdc_busy  <= 1'b0;
                acsi_busy <= 1'b0;
                last_acsi <= owner_acsi;
            end
        end
    end

endmodule

// File: tb/tb_sd_sector_arbiter.sv
// Directed self-checking bench for sd_sector_arbiter with a short watchdog (TIMEOUT_W=4).
// Inputs change and outputs are sampled on the falling clock edge.
`timescale 1ns/1ps
module tb_sd_sector_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  fdc_rd_req, fdc_wr_req, acsi_rd_req, acsi_wr_req;
    logic [31:0] fdc_lba, acsi_lba;
    logic [15:0] acsi_length;
    logic        fdc_busy, acsi_busy, fdc_done, acsi_done;
    logic [3:0]  sd_rd, sd_wr;
    logic [31:0] sd_lba;
    logic [15:0] sd_length;
    logic        sd_busy, sd_done, timeout_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sd_sector_arbiter #(.TIMEOUT_W(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .fdc_rd_req  (fdc_rd_req),
        .fdc_wr_req  (fdc_wr_req),
        .fdc_lba     (fdc_lba),
        .acsi_rd_req (acsi_rd_req),
        .acsi_wr_req (acsi_wr_req),
        .acsi_lba    (acsi_lba),
        .acsi_length (acsi_length),
        .fdc_busy    (fdc_busy),
        .acsi_busy   (acsi_busy),
        .fdc_done    (fdc_done),
        .acsi_done   (acsi_done),
        .sd_rd       (sd_rd),
        .sd_wr       (sd_wr),
        .sd_lba      (sd_lba),
        .sd_length   (sd_length),
        .sd_busy     (sd_busy),
        .sd_done     (sd_done),
        .timeout_err (timeout_err)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rdwr"},   32'({sd_rd, sd_wr}), 32'h0);
        check({tag, "_busy"},   32'({fdc_busy, acsi_busy}), 32'h0);
        check({tag, "_done"},   32'({fdc_done, acsi_done, timeout_err}), 32'h0);
    endtask

    // Plays the SD controller for one transfer and drops the served request bit once busy is seen.
    task automatic serve(input string tag, input logic [3:0] exp_rd, input logic [3:0] exp_wr,
                         input logic [31:0] exp_lba, input logic [15:0] exp_len, input int busy_delay);
        logic        found;
        logic        own_a;
        logic [31:0] f_lba, a_lba;
        found = 1'b0;
        own_a = |(exp_rd[3:2] | exp_wr[3:2]);
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            found = (sd_rd != 4'b0) || (sd_wr != 4'b0);
        end
        check({tag, "_grant_seen"}, 32'(found), 32'h1);
        if (!found) return;
        check({tag, "_sd_rd"},     32'(sd_rd), 32'(exp_rd));
        check({tag, "_sd_wr"},     32'(sd_wr), 32'(exp_wr));
        check({tag, "_sd_lba"},    sd_lba, exp_lba);
        check({tag, "_sd_length"}, 32'(sd_length), 32'(exp_len));
        check({tag, "_busy_pre"},  32'({fdc_busy, acsi_busy}), 32'h0);

        // Scramble address inputs; the latched values must not follow them.
        f_lba    = fdc_lba;
        a_lba    = acsi_lba;
        fdc_lba  = ~fdc_lba;
        acsi_lba = ~acsi_lba;

        for (int i = 0; i < busy_delay; i++) begin
            sd_done = 1'b1;
            @(negedge clk);
            check({tag, "_issue_hold"}, 32'({sd_rd, sd_wr}), 32'({exp_rd, exp_wr}));
            check({tag, "_issue_nodone"}, 32'({fdc_done, acsi_done}), 32'h0);
        end
        sd_done = 1'b0;
        sd_busy = 1'b1;
        @(negedge clk);
        sd_busy = 1'b0;
        check({tag, "_rdwr_cleared"}, 32'({sd_rd, sd_wr}), 32'h0);
        check({tag, "_busy_set"},     32'({fdc_busy, acsi_busy}), 32'({~own_a, own_a}));
        fdc_rd_req  = fdc_rd_req  & ~exp_rd[1:0];
        fdc_wr_req  = fdc_wr_req  & ~exp_wr[1:0];
        acsi_rd_req = acsi_rd_req & ~exp_rd[3:2];
        acsi_wr_req = acsi_wr_req & ~exp_wr[3:2];

        repeat (2) @(negedge clk);
        check({tag, "_busy_hold"}, 32'({fdc_busy, acsi_busy}), 32'({~own_a, own_a}));
        sd_done = 1'b1;
        @(negedge clk);
        sd_done = 1'b0;
        check({tag, "_done_pulse"}, 32'({fdc_done, acsi_done}), 32'({~own_a, own_a}));
        check({tag, "_busy_release"}, 32'({fdc_busy, acsi_busy}), 32'({~own_a, own_a}));
        check({tag, "_lba_stable"}, sd_lba, exp_lba);
        @(negedge clk);
        check({tag, "_done_end"}, 32'({fdc_done, acsi_done}), 32'h0);
        check({tag, "_busy_end"}, 32'({fdc_busy, acsi_busy}), 32'h0);
        fdc_lba  = f_lba;
        acsi_lba = a_lba;
    endtask

    task automatic apply_reset();
        reset       = 1'b1;
        fdc_rd_req  = '0;
        fdc_wr_req  = '0;
        acsi_rd_req = '0;
        acsi_wr_req = '0;
        fdc_lba     = '0;
        acsi_lba    = '0;
        acsi_length = '0;
        sd_busy     = 1'b0;
        sd_done     = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit: got running expected finished");
        $fatal(1, "time limit");
    end

    initial begin
        int   rd_cycles, to_pulses, dones;
        logic found;

        apply_reset();
        check_idle_outputs("reset");
        check("reset_lba", sd_lba, 32'h0);
        check("reset_len", 32'(sd_length), 32'h0);

        // Single ACSI read, busy after 3 cycles in ISSUE.
        acsi_rd_req = 2'b01;
        acsi_lba    = 32'h100;
        acsi_length = 16'd4;
        serve("acsi_rd", 4'b0100, 4'b0000, 32'h100, 16'd4, 3);

        // Simultaneous floppy write + ACSI read after reset: floppy first.
        apply_reset();
        fdc_wr_req  = 2'b10;
        fdc_lba     = 32'h22;
        acsi_rd_req = 2'b01;
        acsi_lba    = 32'h300;
        acsi_length = 16'd8;
        serve("tie_fdc",  4'b0000, 4'b0010, 32'h22,  16'd1, 1);
        serve("tie_acsi", 4'b0100, 4'b0000, 32'h300, 16'd8, 0);

        // Continuous requests from both clients alternate F,A,F,A.
        fdc_rd_req  = 2'b11;
        acsi_rd_req = 2'b11;
        fdc_lba     = 32'hF0;
        acsi_lba    = 32'hA0;
        acsi_length = 16'd2;
        serve("rr1_fdc",  4'b0001, 4'b0000, 32'hF0, 16'd1, 0);
        serve("rr2_acsi", 4'b0100, 4'b0000, 32'hA0, 16'd2, 0);
        serve("rr3_fdc",  4'b0010, 4'b0000, 32'hF0, 16'd1, 0);
        serve("rr4_acsi", 4'b1000, 4'b0000, 32'hA0, 16'd2, 0);

        // Several bits within one client: target 0 read, then target 0 write, then target 1 read.
        acsi_rd_req = 2'b11;
        acsi_wr_req = 2'b01;
        acsi_lba    = 32'h55;
        acsi_length = 16'd1;
        serve("pri_rd0", 4'b0100, 4'b0000, 32'h55, 16'd1, 0);
        serve("pri_wr0", 4'b0000, 4'b0100, 32'h55, 16'd1, 0);
        serve("pri_rd1", 4'b1000, 4'b0000, 32'h55, 16'd1, 0);

        // Watchdog: sd_busy never comes, 15 cycles in ISSUE then one timeout pulse.
        fdc_rd_req = 2'b01;
        fdc_lba    = 32'h5;
        rd_cycles  = 0;
        to_pulses  = 0;
        dones      = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (sd_rd != 4'b0) rd_cycles++;
            if (fdc_done || acsi_done) dones++;
            if (timeout_err) begin
                to_pulses++;
                check("wd_rd_cleared", 32'({sd_rd, sd_wr}), 32'h0);
                fdc_rd_req = 2'b00;
            end
        end
        check("wd_issue_cycles", 32'(rd_cycles), 32'd15);
        check("wd_pulses",       32'(to_pulses), 32'd1);
        check("wd_no_done",      32'(dones), 32'd0);
        check_idle_outputs("wd_after");
        fdc_rd_req = 2'b10;
        fdc_lba    = 32'h6;
        serve("wd_recover", 4'b0010, 4'b0000, 32'h6, 16'd1, 0);

        // Reset during BUSY abandons the transfer.
        acsi_wr_req = 2'b10;
        acsi_lba    = 32'h77;
        acsi_length = 16'd2;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            found = (sd_wr != 4'b0);
        end
        check("rst_busy_grant", 32'(sd_wr), 32'b1000);
        sd_busy = 1'b1;
        @(negedge clk);
        sd_busy     = 1'b0;
        acsi_wr_req = 2'b00;
        check("rst_busy_set", 32'(acsi_busy), 32'h1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_idle_outputs("rst_busy");
        check("rst_busy_lba", sd_lba, 32'h0);
        check("rst_busy_len", 32'(sd_length), 32'h0);
        sd_done = 1'b1;
        @(negedge clk);
        sd_done = 1'b0;
        check("rst_idle_done_ignored", 32'({fdc_done, acsi_done}), 32'h0);
        fdc_rd_req = 2'b10;
        fdc_lba    = 32'h9;
        serve("rst_recover", 4'b0010, 4'b0000, 32'h9, 16'd1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
